// File: rtl/uart_ring_sched_pkg.sv
// uart_ring_sched_pkg: shared FSM state encoding, overflow counter width and
// a saturating increment helper for the UART loopback ring-buffer sequencer.
package uart_ring_sched_pkg;

   // Drain sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      SEND    = 2'd2,
      TX_WAIT = 2'd3
   } state_t;

   // Width of the optional overflow event counter.
   localparam int OVF_CNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] val);
      logic [OVF_CNT_W-1:0] res;
      if (val == 16'hFFFF) begin
         res = val;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_ring_sched_ptr.sv
// uart_ring_sched_ptr: circular-buffer bookkeeping. Holds the write and read
// pointers, the fill level and the full/empty flags, all advanced by a
// write-accept strobe and a read-commit strobe. A write request that arrives
// while full is reported as a one-cycle overflow pulse in the next cycle.
module uart_ring_sched_ptr
   import uart_ring_sched_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_accept,
   input  logic              wr_drop,
   input  logic              rd_commit,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W-1:0] rd_ptr,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty,
   output logic              overflow
);

   localparam logic [ADDR_W:0]   LVL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LVL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   LVL_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};

   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W:0]   level_r;
   logic [ADDR_W:0]   level_next_s;
   logic              full_r;
   logic              empty_r;
   logic              overflow_r;

   // Next fill level: a simultaneous write and read commit cancel out.
   always_comb begin
      level_next_s = level_r;
      case ({wr_accept, rd_commit})
         2'b10:   level_next_s = level_r + LVL_ONE;
         2'b01:   level_next_s = level_r - LVL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // Pointer, level, flag and overflow-pulse registers; pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_commit) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r    <= level_next_s;
         full_r     <= (level_next_s == LVL_DEPTH);
         empty_r    <= (level_next_s == LVL_ZERO);
         overflow_r <= wr_drop;
      end
   end

   assign wr_ptr   = wr_ptr_r;
   assign rd_ptr   = rd_ptr_r;
   assign level    = level_r;
   assign full     = full_r;
   assign empty    = empty_r;
   assign overflow = overflow_r;

endmodule

// File: rtl/uart_ring_sched.sv
// uart_ring_sched: sequencer running the UART loopback dual-port RAM as a
// circular buffer. Received bytes are written at the write pointer; while
// running, stored bytes are read (waiting out the RAM read latency) and handed
// to the UART transmitter one at a time. A key press toggles draining.
// Optional build macro UART_RING_OVF_CNT_EN adds a saturating 16-bit ovf_cnt
// output counting dropped bytes.
module uart_ring_sched
   import uart_ring_sched_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_done,
   input  logic              tx_done,
   input  logic              key_flag,
   input  logic              key_state,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [ADDR_W-1:0] addrb,
   output logic              send_en,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
`ifdef UART_RING_OVF_CNT_EN
   output logic [OVF_CNT_W-1:0] ovf_cnt,
`endif
   output logic              running
);

   // Counter wide enough to hold RD_LAT-1.
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              send_en_r;
   logic              running_r;
   logic              toggle_s;
   logic              rd_commit_s;
   logic              wr_drop_s;

   assign toggle_s    = key_flag & ~key_state;
   assign wea         = rx_done & ~full;
   assign wr_drop_s   = rx_done & full;
   assign rd_commit_s = (state_r == TX_WAIT) & tx_done;

   uart_ring_sched_ptr #(
      .ADDR_W (ADDR_W)
   ) u_ptr (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_accept (wea),
      .wr_drop   (wr_drop_s),
      .rd_commit (rd_commit_s),
      .wr_ptr    (addra),
      .rd_ptr    (addrb),
      .level     (level),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
   );

   // Run/pause flag flips on every debounced key press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         running_r <= 1'b0;
      end else begin
         running_r <= running_r ^ toggle_s;
      end
   end

   // Drain FSM: wait out RAM latency, pulse send_en, hold until tx_done commits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         cnt_r     <= CNT_ZERO;
         send_en_r <= 1'b0;
      end else begin
         send_en_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (running_r && !empty) begin
                  state_r <= RD_WAIT;
                  cnt_r   <= CNT_LOAD;
               end
            end
            RD_WAIT: begin
               if (cnt_r == CNT_ZERO) begin
                  state_r   <= SEND;
                  send_en_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            SEND: begin
               state_r <= TX_WAIT;
            end
            TX_WAIT: begin
               if (tx_done) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

`ifdef UART_RING_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_r;

   // Dropped-byte counter, restarted whenever draining is resumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_cnt_r <= {OVF_CNT_W{1'b0}};
      end else if (toggle_s && !running_r) begin
         ovf_cnt_r <= {OVF_CNT_W{1'b0}};
      end else if (overflow) begin
         ovf_cnt_r <= sat_inc(ovf_cnt_r);
      end
   end

   assign ovf_cnt = ovf_cnt_r;
`endif

   assign send_en = send_en_r;
   assign running = running_r;

endmodule

// File: tb/tb_uart_ring_sched.sv
// tb_uart_ring_sched: directed self-checking bench for uart_ring_sched with a
// 4-entry ring (ADDR_W = 2) and the default RAM read latency of 3.
module tb_uart_ring_sched;
   import uart_ring_sched_pkg::*;

   localparam int ADDR_W = 2;
   localparam int RD_LAT = 3;

   logic              clk;
   logic              reset_n;
   logic              rx_done;
   logic              tx_done;
   logic              key_flag;
   logic              key_state;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [ADDR_W-1:0] addrb;
   logic              send_en;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic              running;
`ifdef UART_RING_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt;
`endif

   int n_cmp;
   int n_err;
   int n;
   int hits;

   uart_ring_sched #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_done   (rx_done),
      .tx_done   (tx_done),
      .key_flag  (key_flag),
      .key_state (key_state),
      .wea       (wea),
      .addra     (addra),
      .addrb     (addrb),
      .send_en   (send_en),
      .empty     (empty),
      .full      (full),
      .level     (level),
      .overflow  (overflow),
`ifdef UART_RING_OVF_CNT_EN
      .ovf_cnt   (ovf_cnt),
`endif
      .running   (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press();
      key_flag  = 1'b1;
      key_state = 1'b0;
      step();
      key_flag  = 1'b0;
      key_state = 1'b1;
   endtask

   task automatic rx();
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
   endtask

   task automatic tx();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   // Step until send_en is seen (bounded); cnt is the cycle index of send_en.
   task automatic wait_send(input int start, output int cnt);
      cnt = start;
      while (send_en !== 1'b1 && cnt < 40) begin
         step();
         cnt++;
      end
   endtask

   // Count send_en pulses over k cycles.
   task automatic count_sends(input int k, output int cnt);
      cnt = 0;
      for (int i = 0; i < k; i++) begin
         step();
         if (send_en === 1'b1) cnt++;
      end
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      rx_done   = 1'b0;
      tx_done   = 1'b0;
      key_flag  = 1'b0;
      key_state = 1'b1;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      apply_reset();

      // Reset state
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_send_en", 32'(send_en), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_addra", 32'(addra), 32'd0);
      chk("rst_addrb", 32'(addrb), 32'd0);

      // 1. Basic drain
      press();
      chk("t1_running", 32'(running), 32'd1);
      rx_done = 1'b1;
      #1;
      chk("t1_wea", 32'(wea), 32'd1);
      chk("t1_addra", 32'(addra), 32'd0);
      step();
      rx_done = 1'b0;
      chk("t1_level1", 32'(level), 32'd1);
      wait_send(1, n);
      chk("t1_latency", 32'(n), 32'd5);
      chk("t1_addrb", 32'(addrb), 32'd0);
      step();
      chk("t1_send_one_cycle", 32'(send_en), 32'd0);
      for (int i = 0; i < 9; i++) step();
      chk("t1_level_hold", 32'(level), 32'd1);
      tx();
      chk("t1_level0", 32'(level), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_addrb_next", 32'(addrb), 32'd1);
      tx();
      chk("t1_stray_tx_level", 32'(level), 32'd0);
      chk("t1_stray_tx_addrb", 32'(addrb), 32'd1);

      // 2. Burst and order
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         rx_done = 1'b1;
         #1;
         chk("t2_wea", 32'(wea), 32'd1);
         step();
         rx_done = 1'b0;
      end
      chk("t2_level4", 32'(level), 32'd4);
      count_sends(5, hits);
      chk("t2_paused_no_send", 32'(hits), 32'd0);
      press();
      wait_send(1, n);
      chk("t2_first_latency", 32'(n), 32'd5);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_send(1, n);
            chk("t2_b2b_latency", 32'(n), 32'd5);
         end
         chk("t2_addrb_order", 32'(addrb), 32'(i));
         step();
         step();
         tx();
      end
      chk("t2_level0", 32'(level), 32'd0);
      chk("t2_empty", 32'(empty), 32'd1);
      count_sends(8, hits);
      chk("t2_no_extra_send", 32'(hits), 32'd0);

      // 3. Full and overflow
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         rx_done = 1'b1;
         #1;
         chk("t3_wea_accept", 32'(wea), 32'd1);
         step();
         rx_done = 1'b0;
      end
      chk("t3_full", 32'(full), 32'd1);
      chk("t3_level4", 32'(level), 32'd4);
      chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
      rx_done = 1'b1;
      #1;
      chk("t3_wea_drop", 32'(wea), 32'd0);
      chk("t3_addra_wrap", 32'(addra), 32'd0);
      step();
      rx_done = 1'b0;
      chk("t3_overflow", 32'(overflow), 32'd1);
      chk("t3_level_after", 32'(level), 32'd4);
      chk("t3_addra_kept", 32'(addra), 32'd0);
      step();
      chk("t3_overflow_pulse", 32'(overflow), 32'd0);
`ifdef UART_RING_OVF_CNT_EN
      chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
      press();
      chk("t3_ovf_cnt_clr", 32'(ovf_cnt), 32'd0);
`endif

      // 4. Wrap-around
      apply_reset();
      press();
      for (int r = 0; r < 2; r++) begin
         rx();
         rx();
         rx();
         for (int i = 0; i < 3; i++) begin
            wait_send(0, n);
            chk("t4_send_seen", 32'(send_en), 32'd1);
            chk("t4_addrb", 32'(addrb), 32'((r * 3 + i) % 4));
            step();
            tx();
         end
      end
      chk("t4_empty", 32'(empty), 32'd1);
      chk("t4_level0", 32'(level), 32'd0);

      // 5. Pause mid-transfer
      apply_reset();
      rx();
      rx();
      press();
      step();
      press();
      chk("t5_paused", 32'(running), 32'd0);
      wait_send(0, n);
      chk("t5_send_seen", 32'(send_en), 32'd1);
      chk("t5_addrb0", 32'(addrb), 32'd0);
      step();
      tx();
      chk("t5_level1", 32'(level), 32'd1);
      count_sends(10, hits);
      chk("t5_hold_idle", 32'(hits), 32'd0);
      press();
      wait_send(1, n);
      chk("t5_resume_latency", 32'(n), 32'd5);
      chk("t5_addrb1", 32'(addrb), 32'd1);
      step();
      tx();
      chk("t5_level0", 32'(level), 32'd0);

      // Simultaneous receive and key press
      rx_done   = 1'b1;
      key_flag  = 1'b1;
      key_state = 1'b0;
      step();
      rx_done   = 1'b0;
      key_flag  = 1'b0;
      key_state = 1'b1;
      chk("t7_level", 32'(level), 32'd1);
      chk("t7_running", 32'(running), 32'd0);

      // 6. Async reset in TX_WAIT
      apply_reset();
      rx();
      press();
      wait_send(1, n);
      chk("t6_send_seen", 32'(send_en), 32'd1);
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_level", 32'(level), 32'd0);
      chk("t6_async_empty", 32'(empty), 32'd1);
      chk("t6_async_running", 32'(running), 32'd0);
      chk("t6_async_addra", 32'(addra), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      tx();
      chk("t6_stray_level", 32'(level), 32'd0);
      chk("t6_stray_addrb", 32'(addrb), 32'd0);
      count_sends(10, hits);
      chk("t6_no_send", 32'(hits), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
